// File: rtl/game_scoring.sv
// Game-state and scoring stage: BCD score, pellet/lives bookkeeping, frame-based
// pacman/ghost collision detection and the INIT/PLAY/WIN/LOSE game FSM.
module game_scoring #(
  parameter int unsigned TOTAL_PELLETS = 240,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned H_LAST        = 799,
  parameter int unsigned V_LAST        = 524
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        foodEaten,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        pacmanFill,
  input  logic [3:0]  ghostFill,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        lifeLost,
  output logic        win,
  output logic        lose,
  output logic [1:0]  state
);

  localparam int unsigned PW = $clog2(TOTAL_PELLETS + 1);
  localparam logic [PW-1:0] PELLETS_INIT = PW'(TOTAL_PELLETS);
  localparam logic [1:0]    LIVES_INIT   = 2'(LIVES);
  localparam logic [9:0]    H_END        = 10'(H_LAST);
  localparam logic [9:0]    V_END        = 10'(V_LAST);
  localparam logic [15:0]   SCORE_MAX    = 16'h9990;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     score_q, score_d, score_inc;
  logic [1:0]      lives_q, lives_d;
  logic [PW-1:0]   pellets_q, pellets_d;
  logic            coll_q, coll_d;
  logic            life_lost_q, life_lost_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            coll_now, frame_end, hit, last_pellet;

  // Tens-digit BCD increment; ones digit is always 0, saturates at 9990.
  always_comb begin
    score_inc = score_q;
    if (score_q != SCORE_MAX) begin
      if (score_q[7:4] != 4'd9) begin
        score_inc[7:4] = score_q[7:4] + 4'd1;
      end else begin
        score_inc[7:4] = 4'd0;
        if (score_q[11:8] != 4'd9) begin
          score_inc[11:8] = score_q[11:8] + 4'd1;
        end else begin
          score_inc[11:8]  = 4'd0;
          score_inc[15:12] = score_q[15:12] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    pellets_d   = pellets_q;
    coll_d      = 1'b0;
    life_lost_d = 1'b0;
    coll_now    = pacmanFill & (|ghostFill);
    frame_end   = (hCount == H_END) && (vCount == V_END);
    hit         = 1'b0;
    last_pellet = foodEaten && (pellets_q == PW'(1));

    case (state_q)
      INIT: begin
        score_d   = '0;
        lives_d   = LIVES_INIT;
        pellets_d = PELLETS_INIT;
        if (start) state_d = PLAY;
      end
      PLAY: begin
        coll_d = !frame_end && (coll_q || coll_now);
        hit    = frame_end && (coll_q || coll_now);
        if (foodEaten) begin
          score_d = score_inc;
          if (pellets_q != '0) pellets_d = pellets_q - 1'b1;
        end
        // A win on the same edge as a hit takes priority and spares the life.
        if (last_pellet) begin
          state_d = WIN;
        end else if (hit) begin
          if (lives_q > 2'd1) begin
            lives_d     = lives_q - 2'd1;
            life_lost_d = 1'b1;
          end else begin
            lives_d = '0;
            state_d = LOSE;
          end
        end
      end
      WIN, LOSE: begin
        if (ack) begin
          state_d   = INIT;
          score_d   = '0;
          lives_d   = LIVES_INIT;
          pellets_d = PELLETS_INIT;
        end
      end
      default: state_d = INIT;
    endcase

    win_d  = (state_d == WIN);
    lose_d = (state_d == LOSE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= INIT;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      pellets_q   <= PELLETS_INIT;
      coll_q      <= 1'b0;
      life_lost_q <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      pellets_q   <= pellets_d;
      coll_q      <= coll_d;
      life_lost_q <= life_lost_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign score    = score_q;
  assign lives    = lives_q;
  assign lifeLost = life_lost_q;
  assign win      = win_q;
  assign lose     = lose_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_scoring.sv
// Self-checking bench for game_scoring: table-driven vectors plus hand-written
// sequences, with expected outputs queued at drive time and checked after the edge.
module tb_game_scoring;

  localparam logic [1:0] S_INIT = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_WIN  = 2'b10;
  localparam logic [1:0] S_LOSE = 2'b11;

  logic        clk = 1'b0;
  logic        reset, start, ack, foodEaten, pacmanFill;
  logic [9:0]  hCount, vCount;
  logic [3:0]  ghostFill;
  logic [15:0] score;
  logic [1:0]  lives, state;
  logic        lifeLost, win, lose;

  // 1005 pellets so the score can reach saturation before the maze is cleared.
  game_scoring #(
    .TOTAL_PELLETS(1005),
    .LIVES(3),
    .H_LAST(799),
    .V_LAST(524)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .foodEaten(foodEaten),
    .hCount(hCount), .vCount(vCount), .pacmanFill(pacmanFill), .ghostFill(ghostFill),
    .score(score), .lives(lives), .lifeLost(lifeLost), .win(win), .lose(lose),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, st, ak, food;
    logic [9:0]  h, v;
    logic        pf;
    logic [3:0]  gf;
    logic [1:0]  e_state;
    logic [15:0] e_score;
    logic [1:0]  e_lives;
    logic        e_ll, e_win, e_lose;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   eaten = 0;

  function automatic vec_t mk(logic r, logic s, logic a, logic f, int h, int v,
                              logic pf, logic [3:0] gf, logic [1:0] es,
                              logic [15:0] esc, logic [1:0] el, logic ell,
                              logic ew, logic els);
    vec_t t;
    t.rst_n = r; t.st = s; t.ak = a; t.food = f;
    t.h = 10'(h); t.v = 10'(v); t.pf = pf; t.gf = gf;
    t.e_state = es; t.e_score = esc; t.e_lives = el;
    t.e_ll = ell; t.e_win = ew; t.e_lose = els;
    return t;
  endfunction

  function automatic logic [15:0] bcd_score(int n);
    int v;
    v = ((n > 999) ? 999 : n) * 10;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  task automatic apply(vec_t t);
    vec_t e;
    reset = t.rst_n; start = t.st; ack = t.ak; foodEaten = t.food;
    hCount = t.h; vCount = t.v; pacmanFill = t.pf; ghostFill = t.gf;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("state",    16'(state),    16'(e.e_state));
    chk("score",    score,         e.e_score);
    chk("lives",    16'(lives),    16'(e.e_lives));
    chk("lifeLost", 16'(lifeLost), 16'(e.e_ll));
    chk("win",      16'(win),      16'(e.e_win));
    chk("lose",     16'(lose),     16'(e.e_lose));
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic eat(int n, logic [1:0] cur_lives);
    for (int i = 0; i < n; i++) begin
      eaten++;
      apply(mk(1, 0, 0, 1, 20, 30, 0, 4'h0, S_PLAY, bcd_score(eaten), cur_lives, 0, 0, 0));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; ack = 1'b0; foodEaten = 1'b0;
    hCount = '0; vCount = '0; pacmanFill = 1'b0; ghostFill = '0;
    #1;

    // Reset, INIT ignores ack/food, start enters PLAY, first pellet.
    tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0, 4'h0, S_INIT, 16'h0000, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 799, 524, 1, 4'hF, S_INIT, 16'h0000, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1,   0,   0, 0, 4'h0, S_INIT, 16'h0000, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   0,   0, 0, 4'h0, S_INIT, 16'h0000, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,   0,   0, 0, 4'h0, S_PLAY, 16'h0000, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1,   0,   0, 0, 4'h0, S_PLAY, 16'h0010, 3, 0, 0, 0));
    run_tbl();
    eaten = 1;
    eat(11, 3);

    // Collisions: sticky flag, frame-end commit, partial overlaps, same-cycle hit, lose.
    tbl.push_back(mk(1, 0, 0, 0, 100, 200, 1, 4'b0100, S_PLAY, 16'h0120, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 799,   0, 0, 4'b0000, S_PLAY, 16'h0120, 3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 799, 524, 0, 4'b0000, S_PLAY, 16'h0120, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,   0,   0, 0, 4'b0000, S_PLAY, 16'h0120, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 300,  10, 1, 4'b0000, S_PLAY, 16'h0120, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 300,  11, 0, 4'b1000, S_PLAY, 16'h0120, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 799, 524, 0, 4'b0000, S_PLAY, 16'h0120, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 799, 524, 1, 4'b0001, S_PLAY, 16'h0120, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,   0,   0, 0, 4'b0000, S_PLAY, 16'h0120, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  50,  60, 1, 4'b0010, S_PLAY, 16'h0120, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 799, 524, 0, 4'b0000, S_LOSE, 16'h0120, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 799, 524, 1, 4'b1111, S_LOSE, 16'h0120, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0,   0,   0, 0, 4'b0000, S_INIT, 16'h0000, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,   0,   0, 0, 4'b0000, S_PLAY, 16'h0000, 3, 0, 0, 0));
    run_tbl();

    // Mid-PLAY reset with score 0450 and a pending collision flag.
    eaten = 0;
    eat(45, 3);
    apply(mk(1, 0, 0, 0,   5,   5, 1, 4'h1, S_PLAY, 16'h0450, 3, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 799, 524, 0, 4'h0, S_PLAY, 16'h0450, 2, 1, 0, 0));
    apply(mk(1, 0, 0, 0,   5,   5, 1, 4'h8, S_PLAY, 16'h0450, 2, 0, 0, 0));
    apply(mk(0, 0, 0, 1,   5,   5, 1, 4'h8, S_INIT, 16'h0000, 3, 0, 0, 0));
    apply(mk(1, 1, 0, 0,   0,   0, 0, 4'h0, S_PLAY, 16'h0000, 3, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 799, 524, 0, 4'h0, S_PLAY, 16'h0000, 3, 0, 0, 0));

    // Score saturation at 9990, then the last pellet races a frame-end hit.
    eaten = 0;
    eat(1000, 3);
    chk("score_sat", score, 16'h9990);
    eat(4, 3);
    apply(mk(1, 0, 0, 0,  70,  80, 1, 4'h4, S_PLAY, 16'h9990, 3, 0, 0, 0));
    apply(mk(1, 0, 0, 1, 799, 524, 1, 4'h2, S_WIN,  16'h9990, 3, 0, 1, 0));
    apply(mk(1, 1, 0, 1, 799, 524, 1, 4'hF, S_WIN,  16'h9990, 3, 0, 1, 0));
    apply(mk(1, 0, 1, 0,   0,   0, 0, 4'h0, S_INIT, 16'h0000, 3, 0, 0, 0));
    apply(mk(1, 0, 0, 0,   0,   0, 0, 4'h0, S_INIT, 16'h0000, 3, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
